line_buffer_9x9: RTL and testbench

Raster-to-column converter that sits directly upstream of the 9x9 median filter. It accepts one 8-bit pixel per valid cycle in raster order and stores the previous 8 image lines. For each pixel from row 8 onward, it emits a vertically aligned 9-pixel column (d0_o..d8_o) with a done_o strobe. The median filter's data-modulation stage turns these columns into the 81-element window.

---
 rtl/line_buffer_9x9.sv | 128 ++++++++++++
 tb/tb_line_buffer_9x9.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/line_buffer_9x9.sv
// Raster-to-column converter feeding the 9x9 median filter: eight line memories plus the live pixel form one 9-tap column.
// Optional frame_done_o output is enabled by defining LINE_BUFFER_9X9_FRAME_DONE_EN.

module line_buffer_9x9_line #(
    parameter int COLS = 11,
    parameter int CW   = 4
) (
    input  logic          clk,
    input  logic          we,
    input  logic [CW-1:0] addr,
    input  logic [7:0]    wd,
    output logic [7:0]    rd
);
    logic [7:0] mem [COLS];

    // Read is combinational, so a same-cycle write is seen only on the next access.
    always_ff @(posedge clk) begin
        if (we) mem[addr] <= wd;
    end

    assign rd = mem[addr];
endmodule

module line_buffer_9x9 #(
    parameter int ROWS = 11,
    parameter int COLS = 11
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] pixel_i,
    input  logic       valid_i,
    output logic [7:0] d0_o,
    output logic [7:0] d1_o,
    output logic [7:0] d2_o,
    output logic [7:0] d3_o,
    output logic [7:0] d4_o,
    output logic [7:0] d5_o,
    output logic [7:0] d6_o,
    output logic [7:0] d7_o,
    output logic [7:0] d8_o,
    output logic       done_o
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
    ,
    output logic       frame_done_o
`endif
);
    localparam int NUM_LANES = 8;
    localparam int CW = $clog2(COLS);
    localparam int RW = $clog2(ROWS);
    localparam logic [CW-1:0] COL_LAST = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_LAST = RW'(ROWS - 1);
    localparam logic [RW-1:0] ROW_FIRST_OUT = RW'(8);

    logic [CW-1:0] col_cnt;
    logic [RW-1:0] row_cnt;
    logic          col_last, row_last, we;
    logic [NUM_LANES-1:0][7:0] rd, wd;
    logic [NUM_LANES:0][7:0]   dq;
    logic          done_q;

    assign col_last = (col_cnt == COL_LAST);
    assign row_last = (row_cnt == ROW_LAST);
    // A pixel arriving with reset asserted is dropped, memories included.
    assign we = valid_i && rst;

    // Each lane takes the line above it; the top lane takes the live pixel.
    genvar k;
    generate
        for (k = 0; k < NUM_LANES; k++) begin : g_lane
            if (k == NUM_LANES - 1) begin : g_top
                assign wd[k] = pixel_i;
            end else begin : g_mid
                assign wd[k] = rd[k+1];
            end
            line_buffer_9x9_line #(.COLS(COLS), .CW(CW)) u_line (
                .clk  (clk),
                .we   (we),
                .addr (col_cnt),
                .wd   (wd[k]),
                .rd   (rd[k])
            );
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (!rst) begin
            col_cnt <= '0;
            row_cnt <= '0;
        end else if (valid_i) begin
            if (col_last) begin
                col_cnt <= '0;
                row_cnt <= row_last ? '0 : row_cnt + 1'b1;
            end else begin
                col_cnt <= col_cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            dq     <= '0;
            done_q <= 1'b0;
        end else begin
            done_q <= valid_i && (row_cnt >= ROW_FIRST_OUT);
            if (valid_i) dq <= {pixel_i, rd};
        end
    end

`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
    logic fd_q;
    always_ff @(posedge clk) begin
        if (!rst) fd_q <= 1'b0;
        else      fd_q <= valid_i && row_last && col_last;
    end
    assign frame_done_o = fd_q;
`endif

    assign d0_o   = dq[0];
    assign d1_o   = dq[1];
    assign d2_o   = dq[2];
    assign d3_o   = dq[3];
    assign d4_o   = dq[4];
    assign d5_o   = dq[5];
    assign d6_o   = dq[6];
    assign d7_o   = dq[7];
    assign d8_o   = dq[8];
    assign done_o = done_q;
endmodule

// File: tb/tb_line_buffer_9x9.sv
// Bench for line_buffer_9x9: frame-image reference model, ramp/gap/reset/random frames, plus a 9x2 instance.
module tb_line_buffer_9x9;
    localparam int ROWS = 11;
    localparam int COLS = 11;

    logic       clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic [7:0] pixel;
    logic       valid;
    logic [7:0] d [9];
    logic       done;
    logic [7:0] pix2;
    logic       v2;
    logic [7:0] sd [9];
    logic       sdone;
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
    logic       fd, sfd;
`endif

    line_buffer_9x9 #(.ROWS(ROWS), .COLS(COLS)) dut (
        .clk(clk), .rst(rst), .pixel_i(pixel), .valid_i(valid),
        .d0_o(d[0]), .d1_o(d[1]), .d2_o(d[2]), .d3_o(d[3]), .d4_o(d[4]),
        .d5_o(d[5]), .d6_o(d[6]), .d7_o(d[7]), .d8_o(d[8]),
        .done_o(done)
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
        , .frame_done_o(fd)
`endif
    );

    line_buffer_9x9 #(.ROWS(9), .COLS(2)) dut_small (
        .clk(clk), .rst(rst), .pixel_i(pix2), .valid_i(v2),
        .d0_o(sd[0]), .d1_o(sd[1]), .d2_o(sd[2]), .d3_o(sd[3]), .d4_o(sd[4]),
        .d5_o(sd[5]), .d6_o(sd[6]), .d7_o(sd[7]), .d8_o(sd[8]),
        .done_o(sdone)
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
        , .frame_done_o(sfd)
`endif
    );

    int total = 0;
    int bad = 0;
    int img [ROWS][COLS];
    int mr = 0, mc = 0;
    int ed [9];
    bit edone = 0, efd = 0, known = 0;
    int nstrobe = 0, nfd = 0;
    logic [7:0] fs_d0, fs_d8;
    bit fs_got = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, advance the frame-image model, check all outputs.
    task automatic step(input bit rs, input bit v, input logic [7:0] p);
        rst = rs; valid = v; pixel = p;
        @(posedge clk);
        if (!rs) begin
            mr = 0; mc = 0; edone = 0; efd = 0; known = 1;
            for (int k = 0; k < 9; k++) ed[k] = 0;
        end else if (v) begin
            edone = (mr >= 8);
            efd = (mr == ROWS - 1) && (mc == COLS - 1);
            known = edone;
            if (edone)
                for (int k = 0; k < 8; k++) ed[k] = img[mr - 8 + k][mc];
            ed[8] = int'(p);
            img[mr][mc] = int'(p);
            if (mc == COLS - 1) begin
                mc = 0;
                mr = (mr == ROWS - 1) ? 0 : mr + 1;
            end else begin
                mc = mc + 1;
            end
        end else begin
            edone = 0; efd = 0;
        end
        #1;
        chk("done", 32'(done), 32'(edone));
        chk("d8", 32'(d[8]), 32'(ed[8]));
        if (known)
            for (int k = 0; k < 8; k++) chk($sformatf("d%0d", k), 32'(d[k]), 32'(ed[k]));
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
        chk("frame_done", 32'(fd), 32'(efd));
        if (fd === 1'b1) nfd++;
`endif
        if (done === 1'b1) begin
            nstrobe++;
            if (!fs_got) begin
                fs_got = 1; fs_d0 = d[0]; fs_d8 = d[8];
            end
        end
    endtask

    // gapmode 0: continuous ramp; 1: ramp with every third cycle idle; 2: random pixels and gaps.
    task automatic run_frame(input int off, input int gapmode);
        int cyc;
        logic [7:0] p;
        cyc = 0; nstrobe = 0; fs_got = 0;
        for (int r = 0; r < ROWS; r++) begin
            for (int c = 0; c < COLS; c++) begin
                if (gapmode == 1 && cyc % 3 == 2) begin
                    step(1, 0, 8'($urandom));
                    cyc++;
                end
                if (gapmode == 2 && $urandom_range(2) == 0) step(1, 0, 8'($urandom));
                p = (gapmode == 2) ? 8'($urandom) : 8'((r * COLS + c + off) % 256);
                step(1, 1, p);
                cyc++;
            end
        end
        chk("strobes", 32'(nstrobe), 32'((ROWS - 8) * COLS));
    endtask

    initial begin
        int n2;
        rst = 0; valid = 0; pixel = 0; pix2 = 0; v2 = 0;
        for (int k = 0; k < 9; k++) ed[k] = 0;

        step(0, 0, 8'h00);
        step(0, 1, 8'hAA);

        run_frame(0, 0);
        chk("first_d0", 32'(fs_d0), 32'd0);
        chk("first_d8", 32'(fs_d8), 32'd88);
        chk("last_d0", 32'(d[0]), 32'd32);
        chk("last_d8", 32'(d[8]), 32'd120);

        run_frame(0, 1);
        chk("gap_first_d8", 32'(fs_d8), 32'd88);

        run_frame(100, 0);
        chk("f2_first_d0", 32'(fs_d0), 32'd100);
        chk("f2_first_d8", 32'(fs_d8), 32'd188);

        // Stop mid row 9, reset with a valid pixel that must be dropped, then a fresh frame.
        for (int i = 0; i < 9 * COLS + 5; i++) step(1, 1, 8'(i % 256));
        step(0, 1, 8'd55);
        run_frame(0, 0);
        chk("rst_first_d0", 32'(fs_d0), 32'd0);
        chk("rst_first_d8", 32'(fs_d8), 32'd88);

        nfd = 0;
        run_frame(0, 2);
        run_frame(0, 2);
`ifdef LINE_BUFFER_9X9_FRAME_DONE_EN
        chk("frame_done_count", 32'(nfd), 32'd2);
`endif

        // 9x2 image: columns are the even and odd pixels.
        rst = 1; valid = 0;
        n2 = 0;
        for (int i = 0; i < 18; i++) begin
            pix2 = 8'(i); v2 = 1;
            @(posedge clk);
            #1;
            chk("small_done", 32'(sdone), 32'(i >= 16));
            if (i >= 16) begin
                n2++;
                for (int k = 0; k < 9; k++)
                    chk($sformatf("small_d%0d", k), 32'(sd[k]), 32'(2 * k + (i - 16)));
            end
        end
        v2 = 0;
        chk("small_strobes", 32'(n2), 32'd2);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
